subleq_core: RTL

- Parametrised next-generation SUBLEQ processor core.
- Executes one SUBLEQ instruction per four memory transactions: fetch, read A, read B, write B.
- Decoupled from memory through a req/ack bus, so it can sit on single-cycle RAM or on a slow/shared memory.
- Adds signed branch decision, start/halt control, a retired-instruction counter and a configurable reset vector.

---
 rtl/subleq_core.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/subleq_core.sv
// SUBLEQ processor core: fetch, read A, read B, write B over a req/ack memory bus.
// It stops on a taken self-branch and waits in HALT until it is started again.
module subleq_core #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 13,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iStart,
    output logic              oHalted,
    output logic [ADDR_W-1:0] oPC,
    output logic [CNT_W-1:0]  oRetired,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [2:0]        oState
);

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_FETCH = 3'd1,
        S_RD_A  = 3'd2,
        S_RD_B  = 3'd3,
        S_WR_B  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_IP = ADDR_W'(RESET_PC);

    state_t              state;
    logic [1:0]          rst_sync;
    logic                rst_n;
    logic [ADDR_W-1:0]   ip;
    logic [CNT_W-1:0]    retired;
    logic [2*ADDR_W-1:0] instr_bc;
    logic [DATA_W-1:0]   a;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                xfer;
    logic [ADDR_W-1:0]   b_field;
    logic [ADDR_W-1:0]   c_field;
    logic                leq;
    logic [ADDR_W-1:0]   ip_next;

    // Reset asserts asynchronously, releases two clocks after iReset_n rises.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Bus handshake: oMemReq is the valid and iMemAck the ready. A transfer
    // happens in the cycle both are high; until then req/we/addr/wdata hold
    // their values, and the next request may be raised the cycle after.
    assign xfer    = mem_req & iMemAck;
    assign b_field = instr_bc[2*ADDR_W-1:ADDR_W];
    assign c_field = instr_bc[ADDR_W-1:0];

    // In WR_B the write data register already holds B - A.
    assign leq     = mem_wdata[DATA_W-1] | (mem_wdata == '0);
    assign ip_next = leq ? c_field : ip + ADDR_W'(1);

    always_ff @(posedge iClock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HALT;
            ip        <= RESET_IP;
            retired   <= '0;
            instr_bc  <= '0;
            a         <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_HALT: begin
                    if (iStart) begin
                        state    <= S_FETCH;
                        ip       <= RESET_IP;
                        retired  <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= RESET_IP;
                    end
                end
                S_FETCH: begin
                    if (xfer) begin
                        instr_bc <= iMemRData[2*ADDR_W-1:0];
                        mem_addr <= iMemRData[3*ADDR_W-1:2*ADDR_W];
                        state    <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    if (xfer) begin
                        a        <= iMemRData;
                        mem_addr <= b_field;
                        state    <= S_RD_B;
                    end
                end
                S_RD_B: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= iMemRData - a;
                        state     <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (xfer) begin
                        retired   <= retired + CNT_W'(1);
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        // A taken branch onto itself is the program's stop request.
                        if (leq && (c_field == ip)) begin
                            state    <= S_HALT;
                            mem_req  <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            ip       <= ip_next;
                            mem_addr <= ip_next;
                            state    <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state   <= S_HALT;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign oHalted   = (state == S_HALT);
    assign oPC       = ip;
    assign oRetired  = retired;
    assign oMemReq   = mem_req;
    assign oMemWe    = mem_we;
    assign oMemAddr  = mem_addr;
    assign oMemWData = mem_wdata;
    assign oState    = state;

endmodule
